// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT first-stage butterfly scheduler.
package dct_pkg;

  localparam int unsigned DCT_DATA_W = 16;
  localparam int unsigned DCT_N_PTS  = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/dct_butterfly_sched_adder_block.sv
// Shared add/subtract unit: modulo 2^DATA_W, no saturation, no overflow flag.
module Adder_Block
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = DCT_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result
);

  // Select sum or difference of the two operands
  always_comb begin
    if (op == OP_SUB) result = a - b;
    else              result = a + b;
  end

endmodule

// File: rtl/dct_butterfly_sched.sv
// First butterfly stage of the 8-point DCT: buffers 8 samples, then issues
// 4 sums and 4 differences through one shared adder into a ready/valid stream.
module dct_butterfly_sched
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = DCT_DATA_W,
  parameter int unsigned N_PTS  = DCT_N_PTS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_last
);

  localparam int unsigned CNT_W = $clog2(N_PTS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_PTS - 1);

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] sample_buf [N_PTS];
  logic [CNT_W-1:0]  ld_cnt;
  logic [CNT_W-1:0]  op_cnt;

  logic              accept;
  logic              issue;
  logic              ld_done;
  logic              calc_done;

  logic [CNT_W-1:0]  a_sel;
  logic [CNT_W-1:0]  b_sel;
  logic              op_sel;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_result;

  assign accept    = in_valid && in_ready;
  assign issue     = (state == ST_CALC) && (!out_valid || out_ready);
  assign ld_done   = accept && (ld_cnt == CNT_MAX);
  assign calc_done = issue && (op_cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  // Next-state: leave LOAD on the 8th accept, leave CALC on the last issue
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD: if (ld_done)   state_nx = ST_CALC;
      ST_CALC: if (calc_done) state_nx = ST_LOAD;
      default: state_nx = ST_LOAD;
    endcase
  end

  // FSM outputs: only LOAD accepts samples, and never while in reset
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state == ST_LOAD)) in_ready = 1'b1;
  end

  // Operand select. Both halves pair buf[k] with buf[7-k] (k = op_cnt mod 4):
  // op_cnt-4 and 11-op_cnt reduce to the same low-bit index and its mirror.
  always_comb begin
    a_sel  = {1'b0, op_cnt[CNT_W-2:0]};
    b_sel  = CNT_MAX - a_sel;
    op_sel = op_cnt[CNT_W-1] ? OP_SUB : OP_ADD;
    opnd_a = sample_buf[a_sel];
    opnd_b = sample_buf[b_sel];
  end

  Adder_Block #(
    .DATA_W (DATA_W)
  ) adder_block (
    .a      (opnd_a),
    .b      (opnd_b),
    .op     (op_sel),
    .result (alu_result)
  );

  // Sample buffer; contents are don't-care until rewritten by a new block
  always_ff @(posedge clk) begin
    if (accept) sample_buf[ld_cnt] <= in_data;
  end

  // Load and operation counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
      op_cnt <= '0;
    end else begin
      if (ld_done)     ld_cnt <= '0;
      else if (accept) ld_cnt <= ld_cnt + 1'b1;
      if (calc_done)   op_cnt <= '0;
      else if (issue)  op_cnt <= op_cnt + 1'b1;
    end
  end

  // Output register: an issue overwrites in place, otherwise a handshake empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= alu_result;
      out_idx   <= 3'(op_cnt);
      out_last  <= (op_cnt == CNT_MAX);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_butterfly_sched.sv
// Self-checking bench for dct_butterfly_sched: directed scenarios plus a
// randomized run, all results checked against a block-level reference model.
module tb_dct_butterfly_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;

  dct_butterfly_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        last;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] samp [8];
  int          samp_n = 0;
  logic [15:0] got [8];
  int          blk_start[$];
  int          cyc = 0;
  int          delivered = 0;
  logic        acc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
  endtask

  // Reference: a complete block of 8 samples yields sums then differences
  task automatic model_block();
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: samp[k] + samp[7-k], idx: 3'(k), last: 1'b0});
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: samp[k] - samp[7-k], idx: 3'(k + 4), last: (k == 3)});
  endtask

  // One clock: drive at negedge, observe handshakes, advance to next negedge
  task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy);
    res_t e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("no_spurious_out", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_idx",  32'(out_idx),  32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
        got[out_idx] = out_data;
        delivered++;
      end
    end
    if (acc) begin
      if (samp_n == 0) blk_start.push_back(cyc);
      samp[samp_n] = in_data;
      samp_n++;
      if (samp_n == 8) begin
        model_block();
        samp_n = 0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic load_block(input logic [15:0] x [8], input logic ordy);
    int k = 0;
    int g = 0;
    while (k < 8 && g < 100) begin
      cycle(1'b1, x[k], ordy);
      if (acc) k++;
      g++;
    end
    chk("load_complete", 32'(k), 32'd8);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 100) begin
      cycle(1'b0, 16'h0, 1'b1);
      g++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    samp_n = 0;
    exp_q.delete();
    #1;
  endtask

  logic [15:0] blk_a [8];
  logic [15:0] blk_b [8];
  logic [15:0] seq [16];
  logic [15:0] ref1 [8];
  int          d0;
  int          f;
  int          g;
  logic        seen7;
  logic        iv_r;
  logic        or_r;
  logic [15:0] cur;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Scenario 1: x = 1..8, out_ready high
    ref1 = '{16'd9, 16'd9, 16'd9, 16'd9, 16'hFFF9, 16'hFFFB, 16'hFFFD, 16'hFFFF};
    for (int i = 0; i < 8; i++) blk_a[i] = 16'(i + 1);
    load_block(blk_a, 1'b1);
    chk("lat_no_valid_at_accept", 32'(out_valid), 32'd0);
    chk("calc_in_ready_low", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h0, 1'b0);
    chk("lat_valid_1cyc", 32'(out_valid), 32'd1);
    chk("lat_first_idx", 32'(out_idx), 32'd0);
    chk("calc_no_accept", 32'(acc), 32'd0);
    drain();
    for (int i = 0; i < 8; i++) chk("s1_result", 32'(got[i]), 32'(ref1[i]));

    // Scenario 2: wrap-around arithmetic
    blk_a = '{16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001};
    load_block(blk_a, 1'b1);
    drain();
    chk("wrap_s0", 32'(got[0]), 32'h8000);
    chk("wrap_d0", 32'(got[4]), 32'h7FFE);
    blk_a[0] = 16'h8000;
    load_block(blk_a, 1'b1);
    drain();
    chk("wrap_d0_neg", 32'(got[4]), 32'h7FFF);

    // Scenario 3: backpressure held at idx 2
    for (int i = 0; i < 8; i++) blk_a[i] = 16'(i + 1);
    d0 = delivered;
    load_block(blk_a, 1'b1);
    g = 0;
    while (!(out_valid && out_idx == 3'd2) && g < 20) begin
      cycle(1'b0, 16'h0, 1'b1);
      g++;
    end
    chk("bp_reach_idx2", 32'(out_valid && out_idx == 3'd2), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data",  32'(out_data),  32'd9);
      chk("bp_hold_idx",   32'(out_idx),   32'd2);
    end
    drain();
    chk("bp_count", 32'(delivered - d0), 32'd8);

    // Scenario 4: back-to-back blocks
    for (int i = 0; i < 16; i++) seq[i] = 16'($urandom);
    blk_start.delete();
    f = 0;
    g = 0;
    seen7 = 1'b0;
    while (f < 16 && g < 60) begin
      if (out_valid && out_idx == 3'd7 && !seen7) begin
        seen7 = 1'b1;
        chk("b2b_in_ready_after_last", 32'(in_ready), 32'd1);
      end
      cycle(1'b1, seq[f], 1'b1);
      if (acc) f++;
      g++;
    end
    drain();
    chk("b2b_blocks", 32'(blk_start.size()), 32'd2);
    if (blk_start.size() == 2) chk("b2b_period", 32'(blk_start[1] - blk_start[0]), 32'd16);

    // Scenario 5: reset after 5 accepted samples
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(100 + i), 1'b1);
    do_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    for (int i = 0; i < 8; i++) blk_a[i] = 16'(i + 1);
    load_block(blk_a, 1'b1);
    drain();
    for (int i = 0; i < 8; i++) chk("post_rst_result", 32'(got[i]), 32'(ref1[i]));

    // Scenario 6: 100 random blocks with random gaps and backpressure
    d0 = delivered;
    f = 0;
    g = 0;
    cur = 16'($urandom);
    while ((delivered - d0) < 800 && g < 20000) begin
      iv_r = (f < 800) && ($urandom_range(0, 3) != 0);
      or_r = ($urandom_range(0, 2) != 0);
      cycle(iv_r, cur, or_r);
      if (acc) begin
        f++;
        cur = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      end
      g++;
    end
    drain();
    chk("rand_delivered", 32'(delivered - d0), 32'd800);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
